// File: rtl/stage_id.sv
// RV32I instruction-decode stage: a single-entry holding register fed by IF.
// It decodes the held instruction, checks RAW hazards and issues to EX.
module stage_id (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IR_I,
  input  logic [31:0] PC_I,
  input  logic        Done_I,
  input  logic        Feedback_Branch,
  output logic [4:0]  RF_raddr1,
  output logic [4:0]  RF_raddr2,
  input  logic [31:0] RF_rdata1,
  input  logic [31:0] RF_rdata2,
  input  logic        EX_Wen,
  input  logic        MEM_Wen,
  input  logic        WB_Wen,
  input  logic [4:0]  EX_Rd,
  input  logic [4:0]  MEM_Rd,
  input  logic [4:0]  WB_Rd,
  output logic        Done_O,
  input  logic        Ready_I,
  output logic [31:0] PC_O,
  output logic [31:0] IR_O,
  output logic [31:0] RS1_val,
  output logic [31:0] RS2_val,
  output logic [31:0] Imm,
  output logic [4:0]  Rd,
  output logic        Illegal,
  output logic        Feedback_Stall,
  output logic [31:0] Stall_Cnt
);

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  logic        v_q, v_d;
  logic        taken_q, taken_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  opcode_e     opcode;
  logic [4:0]  rs1, rs2;
  logic        use_rs1, use_rs2, writes_rd, illegal;
  logic [31:0] imm;
  logic        hit1, hit2, hazard;
  logic        done, fire, accept, stall;

  assign opcode = opcode_e'(ir_q[6:0]);
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    imm       = 32'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        use_rs1   = 1'b0;
        writes_rd = 1'b1;
        imm       = {ir_q[31:12], 12'b0};
      end
      OPC_JAL: begin
        use_rs1   = 1'b0;
        writes_rd = 1'b1;
        imm       = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        writes_rd = 1'b1;
        imm       = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OPC_BRANCH: begin
        use_rs2 = 1'b1;
        imm     = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
      OPC_STORE: begin
        use_rs2 = 1'b1;
        imm     = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      OPC_OP: begin
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
  end

  // No forwarding: any in-flight writer of a used, nonzero source blocks issue.
  always_comb begin
    hit1   = (EX_Wen  && (EX_Rd  == rs1)) ||
             (MEM_Wen && (MEM_Rd == rs1)) ||
             (WB_Wen  && (WB_Rd  == rs1));
    hit2   = (EX_Wen  && (EX_Rd  == rs2)) ||
             (MEM_Wen && (MEM_Rd == rs2)) ||
             (WB_Wen  && (WB_Rd  == rs2));
    hazard = v_q && ((use_rs1 && (rs1 != 5'd0) && hit1) ||
                     (use_rs2 && (rs2 != 5'd0) && hit2));
  end

  always_comb begin
    done   = v_q && !hazard && !Feedback_Branch;
    fire   = done && Ready_I;
    stall  = v_q && !fire;
    // taken blocks re-acceptance while IF holds Done_I high for the same instruction.
    accept = Done_I && !taken_q && !Feedback_Branch && (!v_q || fire);

    v_d         = v_q;
    ir_d        = ir_q;
    pc_d        = pc_q;
    taken_d     = Done_I && (taken_q || accept);
    stall_cnt_d = stall_cnt_q + {31'b0, stall};

    if (accept) begin
      v_d  = 1'b1;
      ir_d = IR_I;
      pc_d = PC_I;
    end else if (fire || Feedback_Branch) begin
      v_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= 1'b0;
      taken_q     <= 1'b0;
      stall_cnt_q <= 32'b0;
    end else begin
      v_q         <= v_d;
      taken_q     <= taken_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: datapath holding registers carry no reset; v_q qualifies their contents.
  always_ff @(posedge clk) begin
    ir_q <= ir_d;
    pc_q <= pc_d;
  end

  assign RF_raddr1      = rs1;
  assign RF_raddr2      = rs2;
  assign RS1_val        = RF_rdata1;
  assign RS2_val        = RF_rdata2;
  assign Done_O         = done;
  assign PC_O           = pc_q;
  assign IR_O           = ir_q;
  assign Imm            = imm;
  assign Rd             = writes_rd ? ir_q[11:7] : 5'd0;
  assign Illegal        = illegal;
  assign Feedback_Stall = stall;
  assign Stall_Cnt      = stall_cnt_q;

endmodule
